// File: rtl/udp_echo_responder_if.sv
// Switch-slot handshake bundles: UDP RX/TX header channels and an 8-bit AXI-stream payload channel.
// Pure wiring with valid/ready on every channel; no storage, so no latency and no buffering.

interface UDP_RX_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;

  modport Source (output hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port,
                  input  hdr_ready);
  modport Sink   (input  hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port,
                  output hdr_ready);
endinterface

interface UDP_TX_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport Source (output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
                         source_port, dest_port, length, checksum,
                  input  hdr_ready);
  modport Sink   (input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
                         source_port, dest_port, length, checksum,
                  output hdr_ready);
endinterface

interface AXIS_IF #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport Master (output tdata, tvalid, tlast, tuser, input tready);
  modport Slave  (input  tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/udp_echo_responder.sv
// UDP echo endpoint: buffers one whole datagram, then returns it with IPs/ports swapped; first TX beat <=2 cycles after TX header.
// RX is back-pressured outside IDLE/RECV/DROP; TX honours tready with a 2-entry prefetch so there are no bubbles.

module udp_echo_responder #(
  parameter int         DEPTH = 2048,
  parameter logic [7:0] TTL   = 8'd64
) (
  input  logic            clk,
  input  logic            reset,
  UDP_RX_HEADER_IF.Sink   udp_rx_header_if_sink,
  AXIS_IF.Slave           udp_rx_payload_if_sink,
  UDP_TX_HEADER_IF.Source udp_tx_header_if_source,
  AXIS_IF.Master          udp_tx_payload_if_source,
  output logic [15:0]     drop_count,
  output logic [15:0]     echo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, RECV, HDR, SEND, DROP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, len_q, rd_ptr_q;
  logic [31:0]     src_ip_q, dst_ip_q;
  logic [15:0]     src_port_q, dst_port_q;

  logic [7:0]      mem [DEPTH];
  logic [7:0]      mem_q;
  logic            inflight_q, inflight_last_q;
  logic [7:0]      fifo_dat [2];
  logic [1:0]      fifo_last;
  logic            wr_sel_q, rd_sel_q;
  logic [1:0]      occ_q;

  logic rx_hdr_rdy, rx_rdy, tx_hdr_vld, tx_vld;
  logic wr_en, pf_en, drop_inc, echo_inc;
  logic pop, issue, issue_last, head_last;
  logic [2:0] used;

  // Prefetch credit: entries held plus the read in flight, net of this cycle's pop.
  assign head_last  = fifo_last[rd_sel_q];
  assign pop        = tx_vld & udp_tx_payload_if_source.tready;
  assign used       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = pf_en && (rd_ptr_q < len_q) && (used < 3'd2);
  assign issue_last = (rd_ptr_q == len_q - CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rx_hdr_rdy = 1'b0;
    rx_rdy     = 1'b0;
    tx_hdr_vld = 1'b0;
    tx_vld     = 1'b0;
    wr_en      = 1'b0;
    pf_en      = 1'b0;
    drop_inc   = 1'b0;
    echo_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        rx_hdr_rdy = 1'b1;
        if (udp_rx_header_if_sink.hdr_valid) state_d = RECV;
      end
      RECV: begin
        rx_rdy = 1'b1;
        if (udp_rx_payload_if_sink.tvalid) begin
          if (cnt_q == CW'(DEPTH)) begin
            if (udp_rx_payload_if_sink.tlast) begin
              drop_inc = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = DROP;
            end
          end else if (udp_rx_payload_if_sink.tlast && udp_rx_payload_if_sink.tuser) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            wr_en = 1'b1;
            if (udp_rx_payload_if_sink.tlast) state_d = HDR;
          end
        end
      end
      DROP: begin
        rx_rdy = 1'b1;
        if (udp_rx_payload_if_sink.tvalid && udp_rx_payload_if_sink.tlast) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      HDR: begin
        tx_hdr_vld = 1'b1;
        pf_en      = 1'b1;
        if (udp_tx_header_if_source.hdr_ready) state_d = SEND;
      end
      SEND: begin
        pf_en  = 1'b1;
        tx_vld = (occ_q != 2'd0);
        if (tx_vld && udp_tx_payload_if_source.tready && head_last) begin
          echo_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      len_q           <= '0;
      src_ip_q        <= '0;
      dst_ip_q        <= '0;
      src_port_q      <= '0;
      dst_port_q      <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_sel_q        <= 1'b0;
      rd_sel_q        <= 1'b0;
      occ_q           <= '0;
      drop_count      <= '0;
      echo_count      <= '0;
    end else begin
      if (state_q == IDLE && udp_rx_header_if_sink.hdr_valid) begin
        src_ip_q   <= udp_rx_header_if_sink.ip_source_ip;
        dst_ip_q   <= udp_rx_header_if_sink.ip_dest_ip;
        src_port_q <= udp_rx_header_if_sink.source_port;
        dst_port_q <= udp_rx_header_if_sink.dest_port;
        cnt_q      <= '0;
      end
      if (wr_en) begin
        cnt_q <= cnt_q + CW'(1);
        if (udp_rx_payload_if_sink.tlast) len_q <= cnt_q + CW'(1);
      end

      // Prefetch starts in HDR so the first beat is ready right after the header handshake.
      if (state_q == IDLE) begin
        rd_ptr_q        <= '0;
        inflight_q      <= 1'b0;
        inflight_last_q <= 1'b0;
        wr_sel_q        <= 1'b0;
        rd_sel_q        <= 1'b0;
        occ_q           <= '0;
      end else begin
        inflight_q      <= issue;
        inflight_last_q <= issue_last;
        if (issue)      rd_ptr_q <= rd_ptr_q + CW'(1);
        if (inflight_q) wr_sel_q <= ~wr_sel_q;
        if (pop)        rd_sel_q <= ~rd_sel_q;
        occ_q <= used[1:0];
      end

      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (echo_inc && echo_count != 16'hFFFF) echo_count <= echo_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[AW-1:0]] <= udp_rx_payload_if_sink.tdata;
    mem_q <= mem[rd_ptr_q[AW-1:0]];
    if (inflight_q) begin
      fifo_dat[wr_sel_q]  <= mem_q;
      fifo_last[wr_sel_q] <= inflight_last_q;
    end
  end

  assign udp_rx_header_if_sink.hdr_ready  = rx_hdr_rdy & ~reset;
  assign udp_rx_payload_if_sink.tready    = rx_rdy;

  assign udp_tx_header_if_source.hdr_valid    = tx_hdr_vld;
  assign udp_tx_header_if_source.ip_source_ip = dst_ip_q;
  assign udp_tx_header_if_source.ip_dest_ip   = src_ip_q;
  assign udp_tx_header_if_source.source_port  = dst_port_q;
  assign udp_tx_header_if_source.dest_port    = src_port_q;
  assign udp_tx_header_if_source.length       = 16'(len_q) + 16'd8;
  assign udp_tx_header_if_source.checksum     = 16'd0;
  assign udp_tx_header_if_source.ip_dscp      = 6'd0;
  assign udp_tx_header_if_source.ip_ecn       = 2'd0;
  assign udp_tx_header_if_source.ip_ttl       = TTL;

  assign udp_tx_payload_if_source.tvalid = tx_vld;
  assign udp_tx_payload_if_source.tdata  = fifo_dat[rd_sel_q];
  assign udp_tx_payload_if_source.tlast  = tx_vld & head_last;
  assign udp_tx_payload_if_source.tuser  = 1'b0;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed bench for udp_echo_responder: table of datagrams plus hand-written stall and mid-send reset sequences.
module tb_udp_echo_responder;
  localparam int DEPTH = 64;
  localparam int LIM   = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  UDP_RX_HEADER_IF rx_hdr();
  AXIS_IF          rx_pl();
  UDP_TX_HEADER_IF tx_hdr();
  AXIS_IF          tx_pl();
  logic [15:0] drop_count, echo_count;

  udp_echo_responder #(.DEPTH(DEPTH), .TTL(8'd64)) dut (
    .clk                      (clk),
    .reset                    (rst),
    .udp_rx_header_if_sink    (rx_hdr),
    .udp_rx_payload_if_sink   (rx_pl),
    .udp_tx_header_if_source  (tx_hdr),
    .udp_tx_payload_if_source (tx_pl),
    .drop_count               (drop_count),
    .echo_count               (echo_count)
  );

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] length;
    logic [15:0] csum;
    logic [7:0]  ttl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
  } hdr_rec_t;

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    int          len;
    bit          err;
    logic [7:0]  base;
    bit          rnd;
    int          stall;
    int          hstall;
    bit          echo;
    logic [15:0] exp_len;
    int          exp_ec;
    int          exp_dc;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // TX-side monitor state (written only by the monitor)
  logic [7:0] got_dat[$];
  bit         got_last[$];
  bit         got_user[$];
  hdr_rec_t   got_hdr[$];
  int cyc = 0, hs_cyc = 0, lat = 0, stall_viol = 0, hstall_viol = 0;
  int hold_done = 0, hhold_done = 0;
  bit first_pend = 0, p_stall = 0, p_hstall = 0;
  logic [7:0] p_dat;
  logic       p_last;
  hdr_rec_t   p_hdr;

  // Requests from the main sequence to the monitor
  bit rnd_mode  = 0;
  int hold_req  = 0;
  int hhold_req = 0;

  function automatic hdr_rec_t cur_hdr();
    return '{tx_hdr.ip_source_ip, tx_hdr.ip_dest_ip, tx_hdr.source_port, tx_hdr.dest_port,
             tx_hdr.length, tx_hdr.checksum, tx_hdr.ip_ttl, tx_hdr.ip_dscp, tx_hdr.ip_ecn};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_stall = 0; p_hstall = 0; first_pend = 0;
      tx_pl.tready = 1'b0; tx_hdr.hdr_ready = 1'b0;
    end else begin
      if (p_stall && !(tx_pl.tvalid && tx_pl.tdata == p_dat && tx_pl.tlast == p_last)) stall_viol++;
      if (p_hstall && !(tx_hdr.hdr_valid && cur_hdr() == p_hdr)) hstall_viol++;
      if (tx_hdr.hdr_valid && hhold_done < hhold_req) begin
        tx_hdr.hdr_ready = 1'b0; hhold_done++;
      end else tx_hdr.hdr_ready = 1'b1;
      if (tx_pl.tvalid && hold_done < hold_req) begin
        tx_pl.tready = 1'b0; hold_done++;
      end else if (rnd_mode) tx_pl.tready = 1'($urandom_range(0, 1));
      else tx_pl.tready = 1'b1;
      if (tx_hdr.hdr_valid && tx_hdr.hdr_ready) begin
        got_hdr.push_back(cur_hdr()); hs_cyc = cyc; first_pend = 1;
      end else if (first_pend && tx_pl.tvalid) begin
        lat = cyc - hs_cyc; first_pend = 0;
      end
      if (tx_pl.tvalid && tx_pl.tready) begin
        got_dat.push_back(tx_pl.tdata); got_last.push_back(tx_pl.tlast); got_user.push_back(tx_pl.tuser);
      end
      p_stall  = tx_pl.tvalid && !tx_pl.tready;
      p_dat    = tx_pl.tdata;
      p_last   = tx_pl.tlast;
      p_hstall = tx_hdr.hdr_valid && !tx_hdr.hdr_ready;
      p_hdr    = cur_hdr();
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic send_dgram(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                            input logic [15:0] dp, input int len, input bit err, input logic [7:0] base);
    int t;
    @(negedge clk);
    rx_hdr.hdr_valid = 1'b1; rx_hdr.ip_source_ip = sip; rx_hdr.ip_dest_ip = dip;
    rx_hdr.source_port = sp; rx_hdr.dest_port = dp;
    t = 0;
    while (!rx_hdr.hdr_ready && t < LIM) begin @(negedge clk); t++; end
    chk("rx_hdr_wait", t < LIM, 1);
    @(negedge clk);
    rx_hdr.hdr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      rx_pl.tvalid = 1'b1;
      rx_pl.tdata  = base + 8'(i);
      rx_pl.tlast  = (i == len - 1);
      rx_pl.tuser  = err && (i == len - 1);
      t = 0;
      while (!rx_pl.tready && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) begin chk("rx_beat_wait", 0, 1); break; end
      @(negedge clk);
    end
    rx_pl.tvalid = 1'b0; rx_pl.tlast = 1'b0; rx_pl.tuser = 1'b0;
  endtask

  task automatic run_dgram(input string tag, input vec_t v);
    int h0, b0, sv0, hv0, t, errs, nlast, nuser;
    hdr_rec_t h;
    logic [7:0] e;
    h0 = got_hdr.size(); b0 = got_dat.size(); sv0 = stall_viol; hv0 = hstall_viol;
    rnd_mode = v.rnd; hold_req += v.stall; hhold_req += v.hstall;
    send_dgram(v.sip, v.dip, v.sp, v.dp, v.len, v.err, v.base);
    t = 0;
    if (v.echo) while ((got_dat.size() - b0) < v.len && t < LIM) begin @(negedge clk); t++; end
    else        while (drop_count != 16'(v.exp_dc) && t < LIM) begin @(negedge clk); t++; end
    chk({tag, " done_wait"}, t < LIM, 1);
    repeat (10) @(negedge clk);
    rnd_mode = 0;
    chk({tag, " hdr_count"}, got_hdr.size() - h0, v.echo ? 1 : 0);
    chk({tag, " beat_count"}, got_dat.size() - b0, v.echo ? v.len : 0);
    if (v.echo && got_hdr.size() > h0) begin
      h = got_hdr[h0];
      chk({tag, " ips"}, {h.sip, h.dip}, {v.dip, v.sip});
      chk({tag, " ports"}, {h.sp, h.dp}, {v.dp, v.sp});
      chk({tag, " length"}, h.length, v.exp_len);
      chk({tag, " csum_ttl_dscp_ecn"}, {h.csum, h.ttl, h.dscp, h.ecn}, {16'd0, 8'd64, 6'd0, 2'd0});
      chk({tag, " first_beat_lat_le2"}, lat <= 2, 1);
    end
    if (v.echo) begin
      errs = 0; nlast = 0; nuser = 0;
      for (int i = b0; i < got_dat.size(); i++) begin
        e = v.base + 8'(i - b0);
        if (got_dat[i] !== e) errs++;
        nlast += int'(got_last[i]);
        nuser += int'(got_user[i]);
      end
      chk({tag, " payload_errs"}, errs, 0);
      chk({tag, " tlast_count"}, nlast, 1);
      if (got_dat.size() >= b0 + v.len) chk({tag, " tlast_on_final"}, got_last[b0 + v.len - 1], 1);
      chk({tag, " tuser_count"}, nuser, 0);
    end
    chk({tag, " stall_stability"}, stall_viol - sv0, 0);
    chk({tag, " hdr_stability"}, hstall_viol - hv0, 0);
    if (v.stall > 0) chk({tag, " stalls_applied"}, hold_done, hold_req);
    chk({tag, " echo_count"}, echo_count, 16'(v.exp_ec));
    chk({tag, " drop_count"}, drop_count, 16'(v.exp_dc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int b0, t;

    // sip, dip, sp, dp, len, err, base, rnd, stall, hstall, echo, exp_len, exp_ec, exp_dc
    vecs[0] = '{32'h0A000002, 32'h0A000001, 16'd5000, 16'd7,    16, 0, 8'h00, 0, 0, 0, 1, 16'd24, 1, 0};
    vecs[1] = '{32'hC0A80105, 32'hC0A80109, 16'd1234, 16'd4321, 64, 0, 8'h40, 0, 0, 0, 1, 16'd72, 2, 0};
    vecs[2] = '{32'hC0A80105, 32'hC0A80109, 16'd1234, 16'd4321, 65, 0, 8'h00, 0, 0, 0, 0, 16'd0,  2, 1};
    vecs[3] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 16'hFFFF, 16'h0001, 4,  0, 8'hF0, 0, 0, 0, 1, 16'd12, 3, 1};
    vecs[4] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 16'd10,   16'd20,   70, 0, 8'h11, 0, 0, 0, 0, 16'd0,  3, 2};
    vecs[5] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 16'd10,   16'd20,   8,  1, 8'h22, 0, 0, 0, 0, 16'd0,  3, 3};
    vecs[6] = '{32'h01020304, 32'h05060708, 16'd80,   16'd8080, 5,  0, 8'h7E, 0, 0, 0, 1, 16'd13, 4, 3};
    vecs[7] = '{32'h0A000002, 32'h0A000001, 16'd5000, 16'd7,    64, 0, 8'h00, 1, 0, 0, 1, 16'd72, 5, 3};
    vecs[8] = '{32'h0A000003, 32'h0A000001, 16'd6000, 16'd7,    1,  0, 8'h3C, 0, 0, 0, 1, 16'd9,  6, 3};

    rx_hdr.hdr_valid = 1'b0; rx_hdr.ip_source_ip = '0; rx_hdr.ip_dest_ip = '0;
    rx_hdr.source_port = '0; rx_hdr.dest_port = '0;
    rx_pl.tvalid = 1'b0; rx_pl.tdata = '0; rx_pl.tlast = 1'b0; rx_pl.tuser = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset rx_hdr_ready", rx_hdr.hdr_ready, 0);
    chk("reset rx_tready", rx_pl.tready, 0);
    chk("reset tx_hdr_valid", tx_hdr.hdr_valid, 0);
    chk("reset tx_tvalid_tlast_tuser", {tx_pl.tvalid, tx_pl.tlast, tx_pl.tuser}, 3'b000);
    chk("reset counters", {drop_count, echo_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset rx_hdr_ready", rx_hdr.hdr_ready, 1);

    for (int i = 0; i < 9; i++) run_dgram($sformatf("vec%0d", i), vecs[i]);

    // One-byte echo with TX header and payload both back-pressured
    v = '{32'h0A000002, 32'h0A000001, 16'd5000, 16'd7, 1, 0, 8'hA5, 0, 5, 3, 1, 16'd9, 7, 3};
    run_dgram("stall_1B", v);

    // Reset in the middle of SEND, then a fresh echo
    v = '{32'h0A000002, 32'h0A000001, 16'd5000, 16'd7, 16, 0, 8'h10, 0, 0, 0, 1, 16'd24, 1, 0};
    b0 = got_dat.size();
    send_dgram(v.sip, v.dip, v.sp, v.dp, v.len, v.err, v.base);
    t = 0;
    while ((got_dat.size() - b0) < 3 && t < LIM) begin @(negedge clk); t++; end
    chk("rst_mid wait_3_beats", t < LIM, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid rx_hdr_ready", rx_hdr.hdr_ready, 0);
    chk("rst_mid rx_tready", rx_pl.tready, 0);
    chk("rst_mid tx_hdr_valid", tx_hdr.hdr_valid, 0);
    chk("rst_mid tx_tvalid_tlast_tuser", {tx_pl.tvalid, tx_pl.tlast, tx_pl.tuser}, 3'b000);
    chk("rst_mid counters", {drop_count, echo_count}, 32'd0);
    chk("rst_mid frame_cut_short", (got_dat.size() - b0) < 16, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release rx_hdr_ready", rx_hdr.hdr_ready, 1);
    chk("rst_release tx_tvalid", tx_pl.tvalid, 0);
    v = '{32'h0A000004, 32'h0A000001, 16'd4444, 16'd7, 8, 0, 8'h60, 0, 0, 0, 1, 16'd16, 1, 0};
    run_dgram("post_rst", v);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
